// File: rtl/quiz_responder_n.sv
// Quiz-show responder: first-press lockout, BCD answer countdown and a 4-digit multiplexed display.
// Optional build macro FOUL_DETECT_EN turns a press while idle into a FOUL result.
module quiz_responder_n #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned ANS_TIME = 30,
  parameter int unsigned SEC_DIV  = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic            start,
  input  logic            clr,
  output logic [2:0]      winner,
  output logic            locked,
  output logic            timeout,
  output logic            foul,
  output logic [3:0]      an,
  output logic [7:0]      seg_code
);

  localparam int unsigned SEC_W  = (SEC_DIV  > 1) ? $clog2(SEC_DIV)  : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]  ANS_T  = 4'(ANS_TIME / 10);
  localparam logic [3:0]  ANS_U  = 4'(ANS_TIME % 10);

  localparam logic [3:0] C_DASH  = 4'd10;
  localparam logic [3:0] C_E     = 4'd11;
  localparam logic [3:0] C_F     = 4'd12;
  localparam logic [3:0] C_BLANK = 4'd13;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOCKED, S_TIMEOUT, S_FOUL} state_t;

  state_t            state;
  logic [N_CH-1:0]   btn_m, btn_s;
  logic [3:0]        cd_t, cd_u;
  logic [SEC_W-1:0]  sec_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        scan_idx, nxt_idx;
  logic              any_btn, sec_tick, scan_adv;
  logic [2:0]        first_btn;
  logic [3:0]        d3, d2, cur_code;

  function automatic logic [2:0] lowest(input logic [N_CH-1:0] v);
    lowest = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) if (v[i]) lowest = 3'(i);
  endfunction

  // Active-low {dp,g..a}; dp always off.
  function automatic logic [7:0] seg7(input logic [3:0] c);
    logic [6:0] p;
    case (c)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      C_DASH:  p = 7'h40;
      C_E:     p = 7'h79;
      C_F:     p = 7'h71;
      default: p = 7'h00;
    endcase
    seg7 = {1'b1, ~p};
  endfunction

  // Two-flop synchroniser per button channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  assign any_btn   = |btn_s;
  assign first_btn = lowest(btn_s);
  assign sec_tick  = (state == S_ARMED) && (sec_cnt == SEC_W'(SEC_DIV - 1));

  // Responder FSM with BCD countdown; a press beats a same-cycle final tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      winner  <= 3'd0;
      locked  <= 1'b0;
      timeout <= 1'b0;
      foul    <= 1'b0;
      cd_t    <= ANS_T;
      cd_u    <= ANS_U;
      sec_cnt <= '0;
    end else if (clr) begin
      state   <= S_IDLE;
      winner  <= 3'd0;
      locked  <= 1'b0;
      timeout <= 1'b0;
      foul    <= 1'b0;
      cd_t    <= ANS_T;
      cd_u    <= ANS_U;
      sec_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
`ifdef FOUL_DETECT_EN
          if (any_btn) begin
            state  <= S_FOUL;
            winner <= first_btn;
            foul   <= 1'b1;
          end else
`endif
          if (start) begin
            state   <= S_ARMED;
            cd_t    <= ANS_T;
            cd_u    <= ANS_U;
            sec_cnt <= '0;
          end
        end
        S_ARMED: begin
          if (any_btn) begin
            state  <= S_LOCKED;
            winner <= first_btn;
            locked <= 1'b1;
          end else begin
            sec_cnt <= sec_tick ? '0 : sec_cnt + SEC_W'(1);
            if (sec_tick) begin
              if (cd_t == 4'd0 && cd_u == 4'd1) begin
                cd_u    <= 4'd0;
                state   <= S_TIMEOUT;
                timeout <= 1'b1;
              end else if (cd_u == 4'd0) begin
                cd_u <= 4'd9;
                cd_t <= cd_t - 4'd1;
              end else begin
                cd_u <= cd_u - 4'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Digit content selection.
  always_comb begin
    d3 = C_DASH;
    d2 = C_BLANK;
    if (state == S_LOCKED || state == S_FOUL) d3 = 4'({1'b0, winner} + 4'd1);
    if (state == S_FOUL)         d2 = C_F;
    else if (state == S_TIMEOUT) d2 = C_E;
  end

  assign scan_adv = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign nxt_idx  = scan_adv ? scan_idx + 2'd1 : scan_idx;

  always_comb begin
    case (nxt_idx)
      2'd0:    cur_code = cd_u;
      2'd1:    cur_code = cd_t;
      2'd2:    cur_code = d2;
      default: cur_code = d3;
    endcase
  end

  // Display scan; segments are encoded for the digit enabled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
      an       <= 4'b1110;
      seg_code <= seg7(ANS_U);
    end else begin
      scan_cnt <= scan_adv ? '0 : scan_cnt + SCAN_W'(1);
      scan_idx <= nxt_idx;
      an       <= ~(4'b0001 << nxt_idx);
      seg_code <= seg7(cur_code);
    end
  end

endmodule
